// File: rtl/i2c_reg_target_if.sv
// I2C register target bundle: raw bus pins plus the register-side write
// strobe, status input and busy flag.
interface i2c_reg_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] status_in;
   logic       wr_stb;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   modport slave (
      input  scl_in, sda_in, status_in,
      output sda_oe, wr_stb, wr_addr, wr_data, busy
   );

   modport master (
      output scl_in, sda_in, status_in,
      input  sda_oe, wr_stb, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C register target: 7-bit address match, 8-bit register pointer,
// 256x8 register file with auto-increment bursts, one status register
// returned live from status_in. The bus is oversampled by clk_1us.
module i2c_reg_target #(
   parameter logic [6:0] CHIP_ADDR   = 7'h39,
   parameter logic [7:0] STATUS_ADDR = 8'h42
) (
   input  logic            clk_1us,
   input  logic            reset,
   i2c_reg_target_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
   } state_t;

   logic       scl_meta_reg, scl_sync_reg, scl_prev_reg;
   logic       sda_meta_reg, sda_sync_reg, sda_prev_reg;
   state_t     state_reg, state_next;
   logic [3:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] rx_shift_reg, rx_shift_next;
   logic [7:0] tx_shift_reg, tx_shift_next;
   logic [7:0] ptr_reg, ptr_next;
   logic       rw_reg, rw_next;
   logic       sda_oe_reg, sda_oe_next;
   logic       busy_reg, busy_next;
   logic       wr_stb_reg, wr_stb_next;
   logic [7:0] wr_addr_reg, wr_addr_next;
   logic [7:0] wr_data_reg, wr_data_next;
   logic       wr_en;
   logic [7:0] regfile [256];

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte, rd_byte;

   // Two-flop synchronizers plus a previous-value flop for edge detection
   always_ff @(posedge clk_1us) begin
      if (!reset) begin
         scl_meta_reg <= 1'b1;
         scl_sync_reg <= 1'b1;
         scl_prev_reg <= 1'b1;
         sda_meta_reg <= 1'b1;
         sda_sync_reg <= 1'b1;
         sda_prev_reg <= 1'b1;
      end else begin
         scl_meta_reg <= bus.scl_in;
         scl_sync_reg <= scl_meta_reg;
         scl_prev_reg <= scl_sync_reg;
         sda_meta_reg <= bus.sda_in;
         sda_sync_reg <= sda_meta_reg;
         sda_prev_reg <= sda_sync_reg;
      end
   end

   assign scl_rise  = scl_sync_reg & ~scl_prev_reg;
   assign scl_fall  = ~scl_sync_reg & scl_prev_reg;
   // SDA edges only count as START/STOP when SCL has been stably high
   assign start_det = scl_sync_reg & scl_prev_reg & sda_prev_reg & ~sda_sync_reg;
   assign stop_det  = scl_sync_reg & scl_prev_reg & ~sda_prev_reg & sda_sync_reg;

   assign rx_byte = {rx_shift_reg[6:0], sda_sync_reg};
   assign rd_byte = (ptr_reg == STATUS_ADDR) ? bus.status_in : regfile[ptr_reg];

   // Register file: cleared on reset, written on the 8th bit of a data byte
   always_ff @(posedge clk_1us) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) regfile[i] <= 8'h00;
      end else if (wr_en) begin
         regfile[ptr_reg] <= rx_byte;
      end
   end

   // Protocol state and output registers
   always_ff @(posedge clk_1us) begin
      if (!reset) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= 4'd0;
         rx_shift_reg <= 8'h00;
         tx_shift_reg <= 8'h00;
         ptr_reg      <= 8'h00;
         rw_reg       <= 1'b0;
         sda_oe_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         wr_stb_reg   <= 1'b0;
         wr_addr_reg  <= 8'h00;
         wr_data_reg  <= 8'h00;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         rx_shift_reg <= rx_shift_next;
         tx_shift_reg <= tx_shift_next;
         ptr_reg      <= ptr_next;
         rw_reg       <= rw_next;
         sda_oe_reg   <= sda_oe_next;
         busy_reg     <= busy_next;
         wr_stb_reg   <= wr_stb_next;
         wr_addr_reg  <= wr_addr_next;
         wr_data_reg  <= wr_data_next;
      end
   end

   // Next-state logic; the bit counter runs 0..7 for data, 8/9 across the ACK slot
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      rx_shift_next = rx_shift_reg;
      tx_shift_next = tx_shift_reg;
      ptr_next      = ptr_reg;
      rw_next       = rw_reg;
      sda_oe_next   = sda_oe_reg;
      busy_next     = busy_reg;
      wr_stb_next   = 1'b0;
      wr_addr_next  = wr_addr_reg;
      wr_data_next  = wr_data_reg;
      wr_en         = 1'b0;

      if (stop_det) begin
         state_next   = IDLE;
         bit_cnt_next = 4'd0;
         sda_oe_next  = 1'b0;
         busy_next    = 1'b0;
      end else if (start_det) begin
         state_next   = ADDR;
         bit_cnt_next = 4'd0;
         sda_oe_next  = 1'b0;
      end else begin
         case (state_reg)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  rx_shift_next = rx_byte;
                  bit_cnt_next  = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7) begin
                     if (state_reg == ADDR) begin
                        if (rx_byte[7:1] == CHIP_ADDR) begin
                           state_next = ADDR_ACK;
                           busy_next  = 1'b1;
                           rw_next    = rx_byte[0];
                        end else begin
                           state_next = IGNORE;
                        end
                     end else if (state_reg == PTR) begin
                        ptr_next   = rx_byte;
                        state_next = PTR_ACK;
                     end else begin
                        wr_en        = 1'b1;
                        wr_stb_next  = 1'b1;
                        wr_addr_next = ptr_reg;
                        wr_data_next = rx_byte;
                        ptr_next     = ptr_reg + 8'd1;
                        state_next   = WDATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (scl_fall && bit_cnt_reg == 4'd8) begin
                  sda_oe_next = 1'b1;
               end else if (scl_rise && bit_cnt_reg == 4'd8) begin
                  bit_cnt_next = 4'd9;
               end else if (scl_fall && bit_cnt_reg == 4'd9) begin
                  bit_cnt_next = 4'd0;
                  sda_oe_next  = 1'b0;
                  if (state_reg == ADDR_ACK && rw_reg) begin
                     state_next    = RDATA;
                     tx_shift_next = rd_byte;
                     sda_oe_next   = ~rd_byte[7];
                  end else if (state_reg == ADDR_ACK) begin
                     state_next = PTR;
                  end else begin
                     state_next = WDATA;
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7) state_next = RDATA_ACK;
               end else if (scl_fall && bit_cnt_reg != 4'd0) begin
                  sda_oe_next   = ~tx_shift_reg[6];
                  tx_shift_next = {tx_shift_reg[6:0], 1'b0};
               end
            end
            RDATA_ACK: begin
               if (scl_fall && bit_cnt_reg == 4'd8) begin
                  sda_oe_next = 1'b0;
               end else if (scl_rise && bit_cnt_reg == 4'd8) begin
                  if (sda_sync_reg) begin
                     state_next = IGNORE;
                  end else begin
                     bit_cnt_next = 4'd9;
                     ptr_next     = ptr_reg + 8'd1;
                  end
               end else if (scl_fall && bit_cnt_reg == 4'd9) begin
                  bit_cnt_next  = 4'd0;
                  tx_shift_next = rd_byte;
                  sda_oe_next   = ~rd_byte[7];
                  state_next    = RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sda_oe  = sda_oe_reg;
   assign bus.busy    = busy_reg;
   assign bus.wr_stb  = wr_stb_reg;
   assign bus.wr_addr = wr_addr_reg;
   assign bus.wr_data = wr_data_reg;
endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, open-drain SDA model,
// and a register-file reference model kept as a plain array.
`timescale 1ns/1ps
module tb_i2c_reg_target;
   localparam int HALF = 5;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic sda_line;

   i2c_reg_target_if bus_if ();

   assign sda_line      = sda_m & ~bus_if.sda_oe;
   assign bus_if.scl_in = scl_m;
   assign bus_if.sda_in = sda_line;

   i2c_reg_target #(.CHIP_ADDR(7'h39), .STATUS_ADDR(8'h42)) dut (
      .clk_1us (clk),
      .reset   (reset),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  model_mem [256];
   logic [7:0]  status_val;
   logic [7:0]  wbuf [$];
   logic [15:0] stb_q [$];
   logic        oe_seen   = 1'b0;
   logic        busy_seen = 1'b0;

   // Record every write strobe and whether SDA/busy were ever asserted
   always @(negedge clk) begin
      if (bus_if.wr_stb === 1'b1) stb_q.push_back({bus_if.wr_addr, bus_if.wr_data});
      if (bus_if.sda_oe === 1'b1) oe_seen = 1'b1;
      if (bus_if.busy === 1'b1) busy_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; clks(HALF);
      scl_m = 1'b1; clks(HALF);
      sda_m = 1'b0; clks(HALF);
      scl_m = 1'b0; clks(1);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; clks(HALF);
      scl_m = 1'b1; clks(HALF);
      sda_m = 1'b1; clks(HALF);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    clks(HALF);
      scl_m = 1'b1; clks(HALF);
      scl_m = 1'b0; clks(1);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; clks(HALF);
      scl_m = 1'b1; clks(HALF / 2);
      b = sda_line; clks(HALF - HALF / 2);
      scl_m = 1'b0; clks(1);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] d, output logic oe9);
      for (int i = 7; i >= 0; i--) recv_bit(d[i]);
      sda_m = nack; clks(HALF);
      scl_m = 1'b1; clks(HALF / 2);
      oe9 = bus_if.sda_oe; clks(HALF - HALF / 2);
      scl_m = 1'b0; clks(1);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
   endtask

   task automatic write_txn(input logic [7:0] ptr);
      logic        ack;
      logic [7:0]  p;
      logic [15:0] exp_q [$];
      stb_q.delete();
      bus_start();
      send_byte(8'h72, ack);
      check("wr_addr_ack", 16'(ack), 16'h0);
      check("busy_set", 16'(bus_if.busy), 16'h1);
      send_byte(ptr, ack);
      check("wr_ptr_ack", 16'(ack), 16'h0);
      p = ptr;
      foreach (wbuf[i]) begin
         send_byte(wbuf[i], ack);
         check("wr_data_ack", 16'(ack), 16'h0);
         exp_q.push_back({p, wbuf[i]});
         model_mem[p] = wbuf[i];
         p = p + 8'd1;
      end
      bus_stop();
      check("busy_clr", 16'(bus_if.busy), 16'h0);
      check("wr_count", 16'(stb_q.size()), 16'(exp_q.size()));
      foreach (exp_q[i]) if (i < stb_q.size()) check("wr_event", stb_q[i], exp_q[i]);
      $display("write ptr=%02h bytes=%0d", ptr, wbuf.size());
   endtask

   task automatic read_txn(input logic [7:0] ptr, input int n);
      logic       ack, oe9, last;
      logic [7:0] d, p, exp;
      stb_q.delete();
      bus_start();
      send_byte(8'h72, ack);
      check("rd_addr_ack", 16'(ack), 16'h0);
      send_byte(ptr, ack);
      check("rd_ptr_ack", 16'(ack), 16'h0);
      bus_start();
      send_byte(8'h73, ack);
      check("rd_raddr_ack", 16'(ack), 16'h0);
      p = ptr;
      for (int i = 0; i < n; i++) begin
         exp  = (p == 8'h42) ? status_val : model_mem[p];
         last = (i == n - 1);
         recv_byte(last, d, oe9);
         check("rd_data", 16'(d), 16'(exp));
         check("rd_release", 16'(oe9), 16'h0);
         p = p + 8'd1;
      end
      bus_stop();
      check("rd_busy_clr", 16'(bus_if.busy), 16'h0);
      check("rd_no_wr", 16'(stb_q.size()), 16'h0);
      $display("read ptr=%02h bytes=%0d", ptr, n);
   endtask

   initial begin
      logic       ack;
      logic [7:0] p;
      int         n;

      status_val       = 8'h00;
      bus_if.status_in = status_val;
      model_reset();
      clks(5);
      check("rst_sda_oe", 16'(bus_if.sda_oe), 16'h0);
      check("rst_busy", 16'(bus_if.busy), 16'h0);
      check("rst_wr_stb", 16'(bus_if.wr_stb), 16'h0);
      check("rst_wr_addr", 16'(bus_if.wr_addr), 16'h0);
      check("rst_wr_data", 16'(bus_if.wr_data), 16'h0);
      reset = 1'b1;
      clks(5);

      // Plain two-byte write burst
      wbuf = '{8'hA5, 8'h5A};
      write_txn(8'h10);
      check("last_wr_addr", 16'(bus_if.wr_addr), 16'h11);
      check("last_wr_data", 16'(bus_if.wr_data), 16'h5A);
      read_txn(8'h10, 2);

      // Status register read
      status_val = 8'h3C; bus_if.status_in = status_val;
      read_txn(8'h42, 1);

      // Status address is writable but reads stay live
      wbuf = '{8'h77};
      write_txn(8'h42);
      status_val = 8'hC3; bus_if.status_in = status_val;
      read_txn(8'h41, 2);

      // Pointer wrap on write and read
      wbuf = '{8'h11, 8'h22};
      write_txn(8'hFF);
      read_txn(8'hFF, 2);

      // Wrong chip address
      stb_q.delete(); oe_seen = 1'b0; busy_seen = 1'b0;
      bus_start();
      send_byte(8'h74, ack);
      check("wrong_nack_addr", 16'(ack), 16'h1);
      send_byte(8'h10, ack);
      check("wrong_nack_data", 16'(ack), 16'h1);
      bus_stop();
      check("wrong_oe", 16'(oe_seen), 16'h0);
      check("wrong_busy", 16'(busy_seen), 16'h0);
      check("wrong_no_wr", 16'(stb_q.size()), 16'h0);
      $display("wrong-address transaction");

      // STOP in the middle of an address byte
      oe_seen = 1'b0; busy_seen = 1'b0;
      bus_start();
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      bus_stop();
      check("abort_oe", 16'(oe_seen), 16'h0);
      check("abort_busy", 16'(busy_seen), 16'h0);
      $display("aborted address byte");
      wbuf = '{8'h5C};
      write_txn(8'h80);
      read_txn(8'h80, 1);

      // Reset while the target drives a 0 bit
      wbuf = '{8'h0F};
      write_txn(8'h20);
      bus_start();
      send_byte(8'h72, ack);
      send_byte(8'h20, ack);
      bus_start();
      send_byte(8'h73, ack);
      check("mrst_raddr_ack", 16'(ack), 16'h0);
      clks(3);
      check("mrst_pre_oe", 16'(bus_if.sda_oe), 16'h1);
      reset = 1'b0;
      clks(1);
      check("mrst_oe_rel", 16'(bus_if.sda_oe), 16'h0);
      check("mrst_busy", 16'(bus_if.busy), 16'h0);
      clks(3);
      reset = 1'b1;
      model_reset();
      clks(10);
      $display("reset during read");
      wbuf = '{8'h99};
      write_txn(8'h30);
      read_txn(8'h20, 1);
      read_txn(8'h30, 1);

      // Randomized write/read pairs against the array model
      for (int it = 0; it < 8; it++) begin
         p = 8'($urandom_range(0, 255));
         if (it % 3 == 0) p = 8'h40;
         n = int'($urandom_range(1, 4));
         wbuf.delete();
         for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
         write_txn(p);
         status_val = 8'($urandom); bus_if.status_in = status_val;
         read_txn(p, int'($urandom_range(1, 4)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
